// File: rtl/sig_control.sv
// Highway / country-road traffic-signal controller.
// Moore FSM: the highway rests on green and hands over to the country road on a sensor request.
module sig_control #(
  parameter int Y2R_DELAY = 3,
  parameter int R2G_DELAY = 2
) (
  output logic [1:0] main,
  output logic [1:0] cntry,
  input  logic       car_on_cntry_rd,
  input  logic       clock,
  input  logic       clear
);

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;

  localparam logic [2:0] S0 = 3'd0;  // HWY_GREEN
  localparam logic [2:0] S1 = 3'd1;  // HWY_YELLOW
  localparam logic [2:0] S2 = 3'd2;  // ALL_RED
  localparam logic [2:0] S3 = 3'd3;  // CNTRY_GREEN
  localparam logic [2:0] S4 = 3'd4;  // CNTRY_YELLOW

  localparam int MAXD = (Y2R_DELAY > R2G_DELAY) ? Y2R_DELAY : R2G_DELAY;
  localparam int CW   = (MAXD > 1) ? $clog2(MAXD) : 1;

  localparam logic [CW-1:0] Y2R_LAST = CW'(Y2R_DELAY - 1);
  localparam logic [CW-1:0] R2G_LAST = CW'(R2G_DELAY - 1);

  logic [2:0]    state;
  logic [2:0]    next_state;
  logic [CW-1:0] count;

  always_comb begin
    next_state = S0;
    case (state)
      S0: next_state = car_on_cntry_rd ? S1 : S0;
      S1: next_state = (count == Y2R_LAST) ? S2 : S1;
      S2: next_state = (count == R2G_LAST) ? S3 : S2;
      S3: next_state = car_on_cntry_rd ? S3 : S4;
      S4: next_state = (count == Y2R_LAST) ? S0 : S4;
      default: next_state = S0;
    endcase
  end

  // Any state change restarts the dwell count, so each timed phase begins at 0.
  always_ff @(posedge clock) begin
    if (clear) begin
      state <= S0;
      count <= '0;
    end else begin
      state <= next_state;
      if (next_state != state)
        count <= '0;
      else if (state == S1 || state == S2 || state == S4)
        count <= count + 1'b1;
    end
  end

  always_comb begin
    main  = GREEN;
    cntry = RED;
    case (state)
      S0: begin main = GREEN;  cntry = RED;    end
      S1: begin main = YELLOW; cntry = RED;    end
      S2: begin main = RED;    cntry = RED;    end
      S3: begin main = RED;    cntry = GREEN;  end
      S4: begin main = RED;    cntry = YELLOW; end
      default: begin main = GREEN; cntry = RED; end
    endcase
  end

endmodule

// File: tb/tb_sig_control.sv
// Directed bench for sig_control: default timing plus a Y2R_DELAY=1 / R2G_DELAY=4 instance.
// Outputs are compared as {main, cntry}; inputs change and outputs are sampled 1 unit after a rising edge.
module tb_sig_control;

  logic       clock;
  logic       clear;
  logic       car_on_cntry_rd;
  logic [1:0] main;
  logic [1:0] cntry;
  logic [1:0] main_p;
  logic [1:0] cntry_p;

  int n_cmp;
  int n_bad;

  sig_control dut (
    .main            (main),
    .cntry           (cntry),
    .car_on_cntry_rd (car_on_cntry_rd),
    .clock           (clock),
    .clear           (clear)
  );

  sig_control #(.Y2R_DELAY(1), .R2G_DELAY(4)) dut_p (
    .main            (main_p),
    .cntry           (cntry_p),
    .car_on_cntry_rd (car_on_cntry_rd),
    .clock           (clock),
    .clear           (clear)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    clear = 1'b1;
    car_on_cntry_rd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      car_on_cntry_rd = ~car_on_cntry_rd;
      n_cmp++;
      if ({main, cntry} !== 4'b1000) begin
        n_bad++;
        $display("FAIL reset_hold[%0d] got=%b exp=%b", i, {main, cntry}, 4'b1000);
      end
      n_cmp++;
      if ({main_p, cntry_p} !== 4'b1000) begin
        n_bad++;
        $display("FAIL reset_hold_p[%0d] got=%b exp=%b", i, {main_p, cntry_p}, 4'b1000);
      end
    end
    clear = 1'b0;
    car_on_cntry_rd = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      n_cmp++;
      if ({main, cntry} !== 4'b1000) begin
        n_bad++;
        $display("FAIL idle_green[%0d] got=%b exp=%b", i, {main, cntry}, 4'b1000);
      end
    end
  endtask

  task automatic test_full_cycle;
    if ($time < 200) #(200 - $time);
    car_on_cntry_rd = 1'b1;
    #6;  // t=206
    n_cmp++;
    if ({main, cntry} !== 4'b0100) begin
      n_bad++;
      $display("FAIL fc_yellow@205 got=%b exp=%b", {main, cntry}, 4'b0100);
    end
    #20; // t=226
    n_cmp++;
    if ({main, cntry} !== 4'b0100) begin
      n_bad++;
      $display("FAIL fc_yellow@225 got=%b exp=%b", {main, cntry}, 4'b0100);
    end
    #10; // t=236
    n_cmp++;
    if ({main, cntry} !== 4'b0000) begin
      n_bad++;
      $display("FAIL fc_allred@235 got=%b exp=%b", {main, cntry}, 4'b0000);
    end
    #10; // t=246
    n_cmp++;
    if ({main, cntry} !== 4'b0000) begin
      n_bad++;
      $display("FAIL fc_allred@245 got=%b exp=%b", {main, cntry}, 4'b0000);
    end
    #10; // t=256
    n_cmp++;
    if ({main, cntry} !== 4'b0010) begin
      n_bad++;
      $display("FAIL fc_cgreen@255 got=%b exp=%b", {main, cntry}, 4'b0010);
    end
    #44; // t=300
    car_on_cntry_rd = 1'b0;
    #6;  // t=306
    n_cmp++;
    if ({main, cntry} !== 4'b0001) begin
      n_bad++;
      $display("FAIL fc_cyellow@305 got=%b exp=%b", {main, cntry}, 4'b0001);
    end
    #20; // t=326
    n_cmp++;
    if ({main, cntry} !== 4'b0001) begin
      n_bad++;
      $display("FAIL fc_cyellow@325 got=%b exp=%b", {main, cntry}, 4'b0001);
    end
    #10; // t=336
    n_cmp++;
    if ({main, cntry} !== 4'b1000) begin
      n_bad++;
      $display("FAIL fc_hgreen@335 got=%b exp=%b", {main, cntry}, 4'b1000);
    end
  endtask

  task automatic test_pulse;
    car_on_cntry_rd = 1'b1;
    cyc(1);
    car_on_cntry_rd = 1'b0;
    n_cmp++;
    if ({main, cntry} !== 4'b0100) begin
      n_bad++;
      $display("FAIL pulse_s1 got=%b exp=%b", {main, cntry}, 4'b0100);
    end
    cyc(2);
    n_cmp++;
    if ({main, cntry} !== 4'b0100) begin
      n_bad++;
      $display("FAIL pulse_s1_last got=%b exp=%b", {main, cntry}, 4'b0100);
    end
    cyc(1);
    n_cmp++;
    if ({main, cntry} !== 4'b0000) begin
      n_bad++;
      $display("FAIL pulse_s2 got=%b exp=%b", {main, cntry}, 4'b0000);
    end
    cyc(1);
    n_cmp++;
    if ({main, cntry} !== 4'b0000) begin
      n_bad++;
      $display("FAIL pulse_s2_last got=%b exp=%b", {main, cntry}, 4'b0000);
    end
    cyc(1);
    n_cmp++;
    if ({main, cntry} !== 4'b0010) begin
      n_bad++;
      $display("FAIL pulse_s3 got=%b exp=%b", {main, cntry}, 4'b0010);
    end
    cyc(1);
    n_cmp++;
    if ({main, cntry} !== 4'b0001) begin
      n_bad++;
      $display("FAIL pulse_s4 got=%b exp=%b", {main, cntry}, 4'b0001);
    end
    cyc(2);
    n_cmp++;
    if ({main, cntry} !== 4'b0001) begin
      n_bad++;
      $display("FAIL pulse_s4_last got=%b exp=%b", {main, cntry}, 4'b0001);
    end
    cyc(1);
    n_cmp++;
    if ({main, cntry} !== 4'b1000) begin
      n_bad++;
      $display("FAIL pulse_s0 got=%b exp=%b", {main, cntry}, 4'b1000);
    end
    cyc(2);
    n_cmp++;
    if ({main, cntry} !== 4'b1000) begin
      n_bad++;
      $display("FAIL pulse_s0_stay got=%b exp=%b", {main, cntry}, 4'b1000);
    end
  endtask

  task automatic test_back_to_back;
    car_on_cntry_rd = 1'b1;
    cyc(6);
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if ({main, cntry} !== 4'b0010) begin
        n_bad++;
        $display("FAIL held_s3[%0d] got=%b exp=%b", i, {main, cntry}, 4'b0010);
      end
      cyc(1);
    end
    // Sensor drops for exactly one sampling edge, then returns during S4.
    cyc(-1);
    car_on_cntry_rd = 1'b0;
    cyc(1);
    car_on_cntry_rd = 1'b1;
    n_cmp++;
    if ({main, cntry} !== 4'b0001) begin
      n_bad++;
      $display("FAIL b2b_s4 got=%b exp=%b", {main, cntry}, 4'b0001);
    end
    cyc(2);
    n_cmp++;
    if ({main, cntry} !== 4'b0001) begin
      n_bad++;
      $display("FAIL b2b_s4_last got=%b exp=%b", {main, cntry}, 4'b0001);
    end
    cyc(1);
    n_cmp++;
    if ({main, cntry} !== 4'b1000) begin
      n_bad++;
      $display("FAIL b2b_s0 got=%b exp=%b", {main, cntry}, 4'b1000);
    end
    cyc(1);
    n_cmp++;
    if ({main, cntry} !== 4'b0100) begin
      n_bad++;
      $display("FAIL b2b_restart got=%b exp=%b", {main, cntry}, 4'b0100);
    end
  endtask

  task automatic test_reset_mid;
    // Entered in S1 (first cycle) with the sensor still high.
    cyc(3);
    n_cmp++;
    if ({main, cntry} !== 4'b0000) begin
      n_bad++;
      $display("FAIL mid_s2 got=%b exp=%b", {main, cntry}, 4'b0000);
    end
    clear = 1'b1;
    car_on_cntry_rd = 1'b0;
    cyc(1);
    clear = 1'b0;
    n_cmp++;
    if ({main, cntry} !== 4'b1000) begin
      n_bad++;
      $display("FAIL mid_clr_s2 got=%b exp=%b", {main, cntry}, 4'b1000);
    end
    cyc(1);
    n_cmp++;
    if ({main, cntry} !== 4'b1000) begin
      n_bad++;
      $display("FAIL mid_after_clr got=%b exp=%b", {main, cntry}, 4'b1000);
    end
    car_on_cntry_rd = 1'b1;
    cyc(1);
    car_on_cntry_rd = 1'b0;
    cyc(2);
    n_cmp++;
    if ({main, cntry} !== 4'b0100) begin
      n_bad++;
      $display("FAIL mid_full_yellow got=%b exp=%b", {main, cntry}, 4'b0100);
    end
    cyc(1);
    n_cmp++;
    if ({main, cntry} !== 4'b0000) begin
      n_bad++;
      $display("FAIL mid_yellow_end got=%b exp=%b", {main, cntry}, 4'b0000);
    end
    cyc(3);
    n_cmp++;
    if ({main, cntry} !== 4'b0001) begin
      n_bad++;
      $display("FAIL mid_s4 got=%b exp=%b", {main, cntry}, 4'b0001);
    end
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    n_cmp++;
    if ({main, cntry} !== 4'b1000) begin
      n_bad++;
      $display("FAIL mid_clr_s4 got=%b exp=%b", {main, cntry}, 4'b1000);
    end
  endtask

  task automatic test_param;
    clear = 1'b1;
    car_on_cntry_rd = 1'b0;
    cyc(1);
    clear = 1'b0;
    car_on_cntry_rd = 1'b1;
    cyc(1);
    car_on_cntry_rd = 1'b0;
    n_cmp++;
    if ({main_p, cntry_p} !== 4'b0100) begin
      n_bad++;
      $display("FAIL par_s1 got=%b exp=%b", {main_p, cntry_p}, 4'b0100);
    end
    cyc(1);
    n_cmp++;
    if ({main_p, cntry_p} !== 4'b0000) begin
      n_bad++;
      $display("FAIL par_s2_first got=%b exp=%b", {main_p, cntry_p}, 4'b0000);
    end
    cyc(3);
    n_cmp++;
    if ({main_p, cntry_p} !== 4'b0000) begin
      n_bad++;
      $display("FAIL par_s2_last got=%b exp=%b", {main_p, cntry_p}, 4'b0000);
    end
    cyc(1);
    n_cmp++;
    if ({main_p, cntry_p} !== 4'b0010) begin
      n_bad++;
      $display("FAIL par_s3 got=%b exp=%b", {main_p, cntry_p}, 4'b0010);
    end
    cyc(1);
    n_cmp++;
    if ({main_p, cntry_p} !== 4'b0001) begin
      n_bad++;
      $display("FAIL par_s4 got=%b exp=%b", {main_p, cntry_p}, 4'b0001);
    end
    cyc(1);
    n_cmp++;
    if ({main_p, cntry_p} !== 4'b1000) begin
      n_bad++;
      $display("FAIL par_s0 got=%b exp=%b", {main_p, cntry_p}, 4'b1000);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clear = 1'b1;
    car_on_cntry_rd = 1'b0;
    test_reset;
    test_full_cycle;
    cyc(2);
    test_pulse;
    test_back_to_back;
    test_reset_mid;
    cyc(2);
    test_param;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
